// File: rtl/led_controller_pkg.sv
// Shared constants for the LED controller: default bus addresses, control-register
// bit layout and PWM counter width.
package led_controller_pkg;

  localparam logic [31:0] DEF_DATA_ADDR = 32'hF000_0000;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'hF000_0100;

  localparam int PWM_W           = 4;
  localparam int CTRL_W          = 8;
  localparam int CTRL_EN         = 0;
  localparam int CTRL_BLINK      = 1;
  localparam int CTRL_OVR        = 2;
  localparam int CTRL_BUSY       = 3;
  localparam int CTRL_BRIGHT_LSB = 4;
  localparam int CTRL_BRIGHT_MSB = 7;

  localparam logic [PWM_W-1:0] BRIGHT_RST = '1;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [PWM_W-1:0] bright,
                                                   input logic busy, input logic ovr,
                                                   input logic blink, input logic en);
    logic [CTRL_W-1:0] r;
    r = '0;
    r[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB] = bright;
    r[CTRL_BUSY]  = busy;
    r[CTRL_OVR]   = ovr;
    r[CTRL_BLINK] = blink;
    r[CTRL_EN]    = en;
    return r;
  endfunction

endpackage

// File: rtl/led_pwm_timer.sv
// Free-running 4-bit PWM frame counter plus blink prescaler/phase toggle.
// Outputs are straight from flops (frame decodes the current count); never stalls.
module led_pwm_timer
  import led_controller_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PWM_W-1:0] pwm_cnt,
  output logic             frame,
  output logic             phase
);

  localparam int PW = $clog2(BLINK_DIV);

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             phase_q, phase_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    presc_d   = presc_q + 1'b1;
    phase_d   = phase_q;
    if (presc_q == PW'(BLINK_DIV - 1)) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      phase_q   <= 1'b1;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;
  assign frame   = (pwm_cnt_q == '1);
  assign phase   = phase_q;

endmodule

// File: rtl/led_controller.sv
// Memory-mapped LED driver: shadowed data register applied at PWM frame boundaries.
// leds lag the PWM/phase state by one clock; bus reads are combinational, writes never stall.
module led_controller
  import led_controller_pkg::*;
#(
  parameter int               DBITS        = 32,
  parameter logic [DBITS-1:0] MY_NAMESPACE = DBITS'(DEF_DATA_ADDR),
  parameter logic [DBITS-1:0] LCTRL_ADDR   = DBITS'(DEF_CTRL_ADDR),
  parameter int               LWIDTH       = 10,
  parameter int               BLINK_DIV    = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire [DBITS-1:0]   dbus,
  input  logic [DBITS-1:0]  address,
  input  logic              wrtEn,
  output logic [LWIDTH-1:0] leds
);

  localparam int UPPER_LSB = (LWIDTH > CTRL_W) ? LWIDTH : CTRL_W;

  logic [PWM_W-1:0]  pwm_cnt;
  logic              frame, phase;
  logic              data_wr, ctrl_wr;
  logic              rd_en;
  logic [DBITS-1:0]  rd_dat;
  logic              unused_dbus;

  logic [LWIDTH-1:0] shadow_q, shadow_d;
  logic [LWIDTH-1:0] applied_q, applied_d;
  logic [LWIDTH-1:0] leds_q, leds_d;
  logic              pending_q, pending_d;
  logic              ovr_q, ovr_d;
  logic              en_q, en_d;
  logic              blink_q, blink_d;
  logic [PWM_W-1:0]  bright_q, bright_d;

  led_pwm_timer #(.BLINK_DIV(BLINK_DIV)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .pwm_cnt (pwm_cnt),
    .frame   (frame),
    .phase   (phase)
  );

  assign data_wr     = wrtEn && (address == MY_NAMESPACE);
  assign ctrl_wr     = wrtEn && (address == LCTRL_ADDR);
  assign unused_dbus = ^dbus[DBITS-1:UPPER_LSB];

  always_comb begin
    shadow_d  = shadow_q;
    applied_d = applied_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;
    en_d      = en_q;
    blink_d   = blink_q;
    bright_d  = bright_q;

    // Boundary copy uses the pre-write shadow; a same-cycle write below re-arms pending.
    if (frame && pending_q) begin
      applied_d = shadow_q;
      pending_d = 1'b0;
    end
    if (ctrl_wr) begin
      en_d     = dbus[CTRL_EN];
      blink_d  = dbus[CTRL_BLINK];
      bright_d = dbus[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB];
      if (!dbus[CTRL_OVR]) ovr_d = 1'b0;
    end
    if (data_wr) begin
      shadow_d  = dbus[LWIDTH-1:0];
      pending_d = 1'b1;
      if (pending_q) ovr_d = 1'b1;
    end

    leds_d = (en_q && (pwm_cnt < bright_q) && (!blink_q || phase)) ? applied_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q  <= '0;
      applied_q <= '0;
      leds_q    <= '0;
      pending_q <= 1'b0;
      ovr_q     <= 1'b0;
      en_q      <= 1'b0;
      blink_q   <= 1'b0;
      bright_q  <= BRIGHT_RST;
    end else begin
      shadow_q  <= shadow_d;
      applied_q <= applied_d;
      leds_q    <= leds_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      en_q      <= en_d;
      blink_q   <= blink_d;
      bright_q  <= bright_d;
    end
  end

  always_comb begin
    rd_en  = 1'b0;
    rd_dat = '0;
    if (!wrtEn && (address == MY_NAMESPACE)) begin
      rd_en  = 1'b1;
      rd_dat = DBITS'(shadow_q);
    end else if (!wrtEn && (address == LCTRL_ADDR)) begin
      rd_en  = 1'b1;
      rd_dat = DBITS'(pack_ctrl(bright_q, pending_q, ovr_q, blink_q, en_q));
    end
  end

  assign dbus = rd_en ? rd_dat : 'z;
  assign leds = leds_q;

endmodule

// File: tb/tb_led_controller.sv
// Directed bench for led_controller with BLINK_DIV=8; cyc counts clocks since reset release,
// so cyc%16 is the PWM position and leds at negedge k reflect position (k-1)%16.
module tb_led_controller;

  localparam logic [31:0] A_DATA = 32'hF000_0000;
  localparam logic [31:0] A_CTRL = 32'hF000_0100;
  localparam logic [31:0] A_NONE = 32'hF000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wrtEn = 1'b0;
  logic        drv = 1'b0;
  logic [31:0] address = A_NONE;
  logic [31:0] drv_dat = '0;
  wire  [31:0] dbus;
  logic [9:0]  leds;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign dbus = drv ? drv_dat : 'z;

  led_controller #(.BLINK_DIV(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .dbus    (dbus),
    .address (address),
    .wrtEn   (wrtEn),
    .leds    (leds)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    address = a; drv_dat = d; drv = 1'b1; wrtEn = 1'b1;
    @(negedge clk);
    wrtEn = 1'b0; drv = 1'b0; address = A_NONE;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] v);
    address = a; wrtEn = 1'b0;
    #1 v = dbus;
    address = A_NONE;
  endtask

  task automatic wait_pwm(input int n);
    for (int i = 0; i < 16 && (cyc % 16) != n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    @(negedge clk);
    checks++; if (leds !== 10'h000) begin errors++; $display("FAIL reset_leds: got %h want %h", leds, 10'h000); end
    do_read(A_CTRL, v);
    checks++; if (v !== 32'h0000_00F0) begin errors++; $display("FAIL reset_ctrl: got %h want %h", v, 32'hF0); end
    do_read(A_DATA, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want %h", v, 32'h0); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] v;
    wait_pwm(1);
    do_write(A_CTRL, 32'hF1);
    do_write(A_DATA, 32'h2A5);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hF9) begin errors++; $display("FAIL basic_busy: got %h want %h", v, 32'hF9); end
    do_read(A_DATA, v);
    checks++; if (v !== 32'h2A5) begin errors++; $display("FAIL basic_shadow: got %h want %h", v, 32'h2A5); end
    wait_pwm(15);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hF9) begin errors++; $display("FAIL basic_busy_pre_frame: got %h want %h", v, 32'hF9); end
    checks++; if (leds !== 10'h000) begin errors++; $display("FAIL basic_not_applied: got %h want %h", leds, 10'h000); end
    @(negedge clk);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hF1) begin errors++; $display("FAIL basic_busy_clear: got %h want %h", v, 32'hF1); end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (leds !== ((i < 16) ? 10'h2A5 : 10'h000)) begin
        errors++; $display("FAIL basic_pwm[%0d]: got %h want %h", i, leds, (i < 16) ? 10'h2A5 : 10'h000);
      end
    end
  endtask

  task automatic test_half_bright();
    do_write(A_CTRL, 32'h81);
    @(negedge clk);
    wait_pwm(1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (leds !== ((i < 8) ? 10'h2A5 : 10'h000)) begin
        errors++; $display("FAIL half_pwm[%0d]: got %h want %h", i, leds, (i < 8) ? 10'h2A5 : 10'h000);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    wait_pwm(3);
    do_write(A_DATA, 32'h001);
    do_write(A_DATA, 32'h3FF);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'h8D) begin errors++; $display("FAIL ovr_set: got %h want %h", v, 32'h8D); end
    do_read(A_DATA, v);
    checks++; if (v !== 32'h3FF) begin errors++; $display("FAIL ovr_shadow: got %h want %h", v, 32'h3FF); end
    wait_pwm(1);
    checks++; if (leds !== 10'h3FF) begin errors++; $display("FAIL ovr_applied: got %h want %h", leds, 10'h3FF); end
    do_write(A_CTRL, 32'h85);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'h85) begin errors++; $display("FAIL ovr_w1_keep: got %h want %h", v, 32'h85); end
    do_write(A_CTRL, 32'h81);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'h81) begin errors++; $display("FAIL ovr_w0_clear: got %h want %h", v, 32'h81); end
    do_write(A_CTRL, 32'h85);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'h81) begin errors++; $display("FAIL ovr_w1_noset: got %h want %h", v, 32'h81); end
    do_write(A_CTRL, 32'h89);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'h81) begin errors++; $display("FAIL ctrl_busy_ro: got %h want %h", v, 32'h81); end
  endtask

  task automatic test_boundary_write();
    logic [31:0] v;
    do_write(A_CTRL, 32'hF1);
    wait_pwm(10);
    do_write(A_DATA, 32'h00F);
    wait_pwm(15);
    do_write(A_DATA, 32'h0F0);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hFD) begin errors++; $display("FAIL bnd_busy_ovr: got %h want %h", v, 32'hFD); end
    do_read(A_DATA, v);
    checks++; if (v !== 32'h0F0) begin errors++; $display("FAIL bnd_shadow: got %h want %h", v, 32'h0F0); end
    checks++; if (leds !== 10'h000) begin errors++; $display("FAIL bnd_off_slot: got %h want %h", leds, 10'h000); end
    @(negedge clk);
    checks++; if (leds !== 10'h00F) begin errors++; $display("FAIL bnd_old_applied: got %h want %h", leds, 10'h00F); end
    wait_pwm(15);
    checks++; if (leds !== 10'h00F) begin errors++; $display("FAIL bnd_old_held: got %h want %h", leds, 10'h00F); end
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hFD) begin errors++; $display("FAIL bnd_still_busy: got %h want %h", v, 32'hFD); end
    @(negedge clk);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hF5) begin errors++; $display("FAIL bnd_busy_clear: got %h want %h", v, 32'hF5); end
    @(negedge clk);
    checks++; if (leds !== 10'h0F0) begin errors++; $display("FAIL bnd_new_applied: got %h want %h", leds, 10'h0F0); end
    do_write(A_CTRL, 32'hF1);
  endtask

  task automatic test_blink_and_bus();
    logic [31:0] v;
    do_write(A_CTRL, 32'hF3);
    @(negedge clk);
    wait_pwm(1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (leds !== ((i < 8) ? 10'h0F0 : 10'h000)) begin
        errors++; $display("FAIL blink_f3[%0d]: got %h want %h", i, leds, (i < 8) ? 10'h0F0 : 10'h000);
      end
      @(negedge clk);
    end
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hF3) begin errors++; $display("FAIL bus_ctrl_read: got %h want %h", v, 32'hF3); end
    do_read(A_DATA, v);
    checks++; if (v !== 32'h0F0) begin errors++; $display("FAIL bus_data_read: got %h want %h", v, 32'h0F0); end
    // Bench drives a pattern itself; any DUT drive would corrupt it.
    address = A_NONE; wrtEn = 1'b0; drv_dat = 32'h5A00_0000; drv = 1'b1;
    #1 v = dbus;
    drv = 1'b0;
    checks++; if (v !== 32'h5A00_0000) begin errors++; $display("FAIL bus_unmapped_z: got %h want %h", v, 32'h5A00_0000); end
    @(negedge clk);
    address = A_CTRL; wrtEn = 1'b1; drv_dat = 32'h43; drv = 1'b1;
    #1 v = dbus;
    checks++; if (v !== 32'h43) begin errors++; $display("FAIL bus_ctrl_write_z: got %h want %h", v, 32'h43); end
    @(negedge clk);
    wrtEn = 1'b0; drv = 1'b0; address = A_NONE;
    @(negedge clk);
    wait_pwm(1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (leds !== ((i < 4) ? 10'h0F0 : 10'h000)) begin
        errors++; $display("FAIL blink_43[%0d]: got %h want %h", i, leds, (i < 4) ? 10'h0F0 : 10'h000);
      end
      @(negedge clk);
    end
    address = A_DATA; wrtEn = 1'b1; drv_dat = 32'h300; drv = 1'b1;
    #1 v = dbus;
    checks++; if (v !== 32'h300) begin errors++; $display("FAIL bus_data_write_z: got %h want %h", v, 32'h300); end
    @(negedge clk);
    wrtEn = 1'b0; drv = 1'b0; address = A_NONE;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int lit;
    do_write(A_CTRL, 32'hF1);
    wait_pwm(2);
    do_write(A_DATA, 32'h155);
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hF9) begin errors++; $display("FAIL mid_pending: got %h want %h", v, 32'hF9); end
    @(negedge clk);
    checks++; if (leds !== 10'h300) begin errors++; $display("FAIL mid_leds_before: got %h want %h", leds, 10'h300); end
    #1 reset = 1'b0;
    #1;
    checks++; if (leds !== 10'h000) begin errors++; $display("FAIL mid_leds_async: got %h want %h", leds, 10'h000); end
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hF0) begin errors++; $display("FAIL mid_ctrl_async: got %h want %h", v, 32'hF0); end
    do_read(A_DATA, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_data_async: got %h want %h", v, 32'h0); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_write(A_CTRL, 32'hF1);
    lit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (leds !== 10'h000) lit++;
    end
    checks++; if (lit !== 0) begin errors++; $display("FAIL mid_no_stale: got %0d lit cycles want 0", lit); end
    do_read(A_CTRL, v);
    checks++; if (v !== 32'hF1) begin errors++; $display("FAIL mid_ctrl_after: got %h want %h", v, 32'hF1); end
    do_write(A_DATA, 32'h0AA);
    wait_pwm(1);
    checks++; if (leds !== 10'h0AA) begin errors++; $display("FAIL mid_new_write: got %h want %h", leds, 10'h0AA); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_half_bright();
    test_overrun();
    test_boundary_write();
    test_blink_and_bus();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_controller.md
LED_CONTROLLER -- requirements
Module: led_controller

Interface
REQ-001 SHALL have parameter DBITS, default 32: bus data/address width.
REQ-002 SHALL have parameter MY_NAMESPACE, default 32'hF000_0000: LED data register address.
REQ-003 SHALL have parameter LCTRL_ADDR, default 32'hF000_0100: LED control/status register address.
REQ-004 SHALL have parameter LWIDTH, default 10: number of LED outputs.
REQ-005 SHALL have parameter BLINK_DIV, default 25_000_000: clocks per blink half-period, minimum 2.
REQ-006 SHALL have port clk, input, 1: the only clock, rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port dbus, inout, DBITS: shared data bus.
REQ-009 SHALL have port address, input, DBITS: bus address.
REQ-010 SHALL have port wrtEn, input, 1: 1 = write cycle, 0 = read cycle.
REQ-011 SHALL have port leds, output, LWIDTH: registered LED drive.

Function
REQ-012 SHALL write dbus[LWIDTH-1:0] into the shadow register on any clk edge with address==MY_NAMESPACE and wrtEn=1, and set pending=1.
REQ-013 SHALL copy shadow into the applied register only at a frame boundary (pwm_cnt==15), then clear pending unless REQ-014 applies.
REQ-014 SHALL, for a data write in the same cycle as a frame boundary, apply the pre-write shadow value and leave pending=1 holding the new value.
REQ-015 SHALL set overrun=1 on any data write while pending=1, with the newer value replacing shadow.
REQ-016 SHALL define the control register as: bit0 enable, bit1 blink, bit2 overrun (R/W0C), bit3 busy (=pending, RO), bits[7:4] bright; all other bits read 0.
REQ-017 SHALL, on a control write, load enable, blink and bright from dbus; dbus[2]=0 clears overrun, dbus[2]=1 has no effect; bit3 is ignored.
REQ-018 SHALL give a simultaneous overrun set and control-write clear priority to the set.
REQ-019 SHALL run pwm_cnt as a 4-bit free-running counter, incrementing every clock and wrapping 15->0.
REQ-020 SHALL run the blink prescaler from 0 to BLINK_DIV-1, wrapping and toggling phase at each wrap.
REQ-021 SHALL register leds <= applied when enable=1, pwm_cnt<bright, and (blink=0 or phase=1); otherwise leds <= 0.
REQ-022 SHALL give leds a latency of 1 clock from the pwm_cnt/phase state; bright=0 means always off, bright=15 means 15 of 16 cycles on.
REQ-023 SHALL drive dbus combinationally with {0, shadow} when address==MY_NAMESPACE and wrtEn=0.
REQ-024 SHALL drive dbus combinationally with {24'd0, control register} when address==LCTRL_ADDR and wrtEn=0.
REQ-025 SHALL otherwise drive dbus to all-Z, and SHALL never drive it during a write cycle.
REQ-026 SHALL have no side effects on reads.

Reset
REQ-027 SHALL, while reset=0, force leds=0, shadow=0, applied=0, pending=0, overrun=0, enable=0, blink=0, bright=4'hF, pwm_cnt=0, prescaler=0, phase=1.
REQ-028 SHALL abandon a pending update on reset assertion mid-operation; the first frame boundary after release applies no stale value.
REQ-029 SHALL keep dbus decode purely combinational during reset, returning reset register values.

Structure
REQ-030 SHALL place the default addresses, control-bit positions (EN=0, BLINK=1, OVR=2, BUSY=3, BRIGHT=7:4) and PWM width in a shared package.
REQ-031 SHALL place pwm_cnt, the prescaler and phase in one sub-module, led_pwm_timer, which outputs pwm_cnt, frame and phase.

Verification (BLINK_DIV=8)
REQ-032 SHALL test: reset, write ctrl 32'hF1, write data 10'h2A5 -> busy=1 until next pwm_cnt==15; then leds=10'h2A5 for 15 of 16 clocks and 0 on the 16th; busy=0.
REQ-033 SHALL test: ctrl 32'h81 -> leds on only for pwm_cnt 0..7, i.e. 8-on/8-off.
REQ-034 SHALL test: two data writes 10'h001 then 10'h3FF before a boundary -> overrun=1 and applied=10'h3FF; ctrl write with bit2=0 -> overrun=0; write with bit2=1 -> overrun unchanged.
REQ-035 SHALL test: data write on the boundary cycle with prior pending 10'h00F, new 10'h0F0 -> 10'h00F applied, busy=1, next frame 10'h0F0, overrun=1.
REQ-036 SHALL test: ctrl 32'hF3 -> leds alternate 8 cycles PWM-on / 8 cycles 0; reads of both addresses return the expected values; dbus=Z for unmapped addresses and write cycles.
REQ-037 SHALL test: reset asserted mid-frame with pending=1 -> leds=0 and busy=0 immediately (asynchronously); after release, leds stay 0 until new writes.
